// File: rtl/sbus_arbiter_if.sv
// Signal bundle between sbus_arbiter, its two requesting masters and the shared SBUS slaves.
// Handshake: a master raises REQ with ADD/WDATA/RNW stable and keeps REQ high until it sees
// a one-cycle ACK; RDATA is valid in that ACK cycle and held afterwards. BUS_RD/BUS_WR are
// single-cycle strobes qualified by BUS_ADD, with read data returned on BUS_DATA_OUT.
interface sbus_arbiter_if;
  logic        M0_REQ;
  logic        M1_REQ;
  logic        M0_RNW;
  logic        M1_RNW;
  logic [15:0] M0_ADD;
  logic [15:0] M1_ADD;
  logic [7:0]  M0_WDATA;
  logic [7:0]  M1_WDATA;
  logic        M0_ACK;
  logic        M1_ACK;
  logic [7:0]  M0_RDATA;
  logic [7:0]  M1_RDATA;
  logic [15:0] BUS_ADD;
  logic [7:0]  BUS_DATA_IN;
  logic [7:0]  BUS_DATA_OUT;
  logic        BUS_RD;
  logic        BUS_WR;
  logic        BUSY;

  modport master (
    input  M0_REQ, M1_REQ, M0_RNW, M1_RNW, M0_ADD, M1_ADD, M0_WDATA, M1_WDATA, BUS_DATA_OUT,
    output M0_ACK, M1_ACK, M0_RDATA, M1_RDATA, BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, BUSY
  );

  modport slave (
    output M0_REQ, M1_REQ, M0_RNW, M1_RNW, M0_ADD, M1_ADD, M0_WDATA, M1_WDATA, BUS_DATA_OUT,
    input  M0_ACK, M1_ACK, M0_RDATA, M1_RDATA, BUS_ADD, BUS_DATA_IN, BUS_RD, BUS_WR, BUSY
  );
endinterface

// File: rtl/sbus_arbiter.sv
// Round-robin two-master arbiter for the 8-bit SBUS: one transaction at a time, single-cycle
// strobe, read data captured RD_LATENCY cycles after the strobe, one-cycle ACK per master.
module sbus_arbiter #(
  parameter int RD_LATENCY = 1
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  sbus_arbiter_if.master bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

  state_t     state;
  logic       last;
  logic       sel;
  logic       rnw_q;
  logic [2:0] cnt;

  logic        both;
  logic        any_req;
  logic        grant;
  logic        g_rnw;
  logic [15:0] g_add;
  logic [7:0]  g_wdata;
  logic        done;

  // On a tie the master not recorded in last wins; single requests leave last alone.
  assign both    = bus.M0_REQ & bus.M1_REQ;
  assign any_req = bus.M0_REQ | bus.M1_REQ;
  assign grant   = both ? ~last : bus.M1_REQ;
  assign g_rnw   = grant ? bus.M1_RNW   : bus.M0_RNW;
  assign g_add   = grant ? bus.M1_ADD   : bus.M0_ADD;
  assign g_wdata = grant ? bus.M1_WDATA : bus.M0_WDATA;

  // Last cycle of the bus phase: read data (if any) is sampled at the end of this cycle.
  assign done = ((state == S_ISSUE) && (!rnw_q || (RD_LATENCY == 0))) ||
                ((state == S_WAIT) && (cnt == 3'd1));

  assign dbg_state = state;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state           <= S_IDLE;
      last            <= 1'b1;
      sel             <= 1'b0;
      rnw_q           <= 1'b0;
      cnt             <= 3'd0;
      bus.M0_ACK      <= 1'b0;
      bus.M1_ACK      <= 1'b0;
      bus.M0_RDATA    <= 8'h00;
      bus.M1_RDATA    <= 8'h00;
      bus.BUS_ADD     <= 16'h0000;
      bus.BUS_DATA_IN <= 8'h00;
      bus.BUS_RD      <= 1'b0;
      bus.BUS_WR      <= 1'b0;
      bus.BUSY        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel             <= grant;
            rnw_q           <= g_rnw;
            if (both) last  <= grant;
            bus.BUS_ADD     <= g_add;
            bus.BUS_DATA_IN <= g_rnw ? 8'h00 : g_wdata;
            bus.BUS_RD      <= g_rnw;
            bus.BUS_WR      <= ~g_rnw;
            bus.BUSY        <= 1'b1;
            state           <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          bus.BUS_RD      <= 1'b0;
          bus.BUS_WR      <= 1'b0;
          bus.BUS_DATA_IN <= 8'h00;
          if (done) begin
            state <= S_ACK;
          end else begin
            cnt   <= 3'(RD_LATENCY);
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) state <= S_ACK;
          else      cnt   <= cnt - 3'd1;
        end
        S_ACK: begin
          bus.M0_ACK <= 1'b0;
          bus.M1_ACK <= 1'b0;
          bus.BUSY   <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (done) begin
        bus.BUS_ADD <= 16'h0000;
        if (sel) begin
          bus.M1_ACK <= 1'b1;
          if (rnw_q) bus.M1_RDATA <= bus.BUS_DATA_OUT;
        end else begin
          bus.M0_ACK <= 1'b1;
          if (rnw_q) bus.M0_RDATA <= bus.BUS_DATA_OUT;
        end
      end
    end
  end

endmodule

// File: tb/tb_sbus_arbiter.sv
// Directed bench for sbus_arbiter: four copies (RD_LATENCY 1, 0, 3, 7) share one stimulus,
// each with a small register slave whose read data is valid only RD_LATENCY cycles after BUS_RD.
module tb_sbus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m1_req, m0_rnw, m1_rnw;
  logic [15:0] m0_add, m1_add;
  logic [7:0]  m0_wdata, m1_wdata;

  int checks = 0;
  int errors = 0;

  logic        ack0_w   [4];
  logic        ack1_w   [4];
  logic [7:0]  rdata0_w [4];
  logic [7:0]  rdata1_w [4];
  logic [15:0] add_w    [4];
  logic [7:0]  din_w    [4];
  logic        rd_w     [4];
  logic        wr_w     [4];
  logic        busy_w   [4];
  logic [1:0]  state_w  [4];
  logic [7:0]  reg1_w   [4];

  logic [15:0] exp_q [$];

  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
    sbus_arbiter_if bif ();
    logic [7:0] regs [16];
    logic [7:0] pipe [8];
    logic [7:0] rd_val;

    sbus_arbiter #(.RD_LATENCY(L)) dut (
      .BUS_CLK   (clk),
      .BUS_RST_N (rst_n),
      .bus       (bif),
      .dbg_state (state_w[g])
    );

    assign bif.M0_REQ   = m0_req;
    assign bif.M1_REQ   = m1_req;
    assign bif.M0_RNW   = m0_rnw;
    assign bif.M1_RNW   = m1_rnw;
    assign bif.M0_ADD   = m0_add;
    assign bif.M1_ADD   = m1_add;
    assign bif.M0_WDATA = m0_wdata;
    assign bif.M1_WDATA = m1_wdata;

    // Slave map: 0x0011 -> 0xA5, 0x0020 -> 0xCD, otherwise a 16-entry register file.
    always_comb begin
      rd_val = regs[bif.BUS_ADD[3:0]];
      if (bif.BUS_ADD == 16'h0011) rd_val = 8'hA5;
      if (bif.BUS_ADD == 16'h0020) rd_val = 8'hCD;
    end

    assign bif.BUS_DATA_OUT = (L == 0) ? (bif.BUS_RD ? rd_val : 8'h00) : pipe[(L == 0) ? 0 : L - 1];

    always @(posedge clk) begin
      if (bif.BUS_WR) regs[bif.BUS_ADD[3:0]] <= bif.BUS_DATA_IN;
      pipe[0] <= bif.BUS_RD ? rd_val : 8'h00;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
    end

    assign ack0_w[g]   = bif.M0_ACK;
    assign ack1_w[g]   = bif.M1_ACK;
    assign rdata0_w[g] = bif.M0_RDATA;
    assign rdata1_w[g] = bif.M1_RDATA;
    assign add_w[g]    = bif.BUS_ADD;
    assign din_w[g]    = bif.BUS_DATA_IN;
    assign rd_w[g]     = bif.BUS_RD;
    assign wr_w[g]     = bif.BUS_WR;
    assign busy_w[g]   = bif.BUSY;
    assign reg1_w[g]   = regs[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // One transaction on lane 0 (RD_LATENCY=1); exp_k is the cycle of ACK counted from the grant edge.
  task automatic run_txn(input bit m, input bit rnw, input logic [15:0] add, input logic [7:0] wd,
                         input int exp_k, input logic [7:0] exp_rd, input string tag);
    int  k;
    bit  got;
    if (m) begin m1_req = 1'b1; m1_rnw = rnw; m1_add = add; m1_wdata = wd; end
    else   begin m0_req = 1'b1; m0_rnw = rnw; m0_add = add; m0_wdata = wd; end
    tick();
    check({tag, " strobe"}, 32'({rd_w[0], wr_w[0]}), 32'({rnw, !rnw}));
    check({tag, " bus_add"}, 32'(add_w[0]), 32'(add));
    check({tag, " data_in"}, 32'(din_w[0]), rnw ? 32'h0 : 32'(wd));
    if (m) begin m1_add = ~add; m1_wdata = ~wd; end
    else   begin m0_add = ~add; m0_wdata = ~wd; end
    k = 1;
    got = 1'b0;
    while (!got && k < 20) begin
      tick();
      k++;
      if (m ? ack1_w[0] : ack0_w[0]) got = 1'b1;
      else if (rnw) check({tag, " wait add"}, 32'({add_w[0], rd_w[0]}), 32'({add, 1'b0}));
    end
    check({tag, " ack cycle"}, 32'(k), 32'(exp_k));
    check({tag, " other ack"}, 32'(m ? ack0_w[0] : ack1_w[0]), 32'h0);
    if (rnw) check({tag, " rdata"}, 32'(m ? rdata1_w[0] : rdata0_w[0]), 32'(exp_rd));
    if (m) m1_req = 1'b0; else m0_req = 1'b0;
    tick();
    check({tag, " idle"}, 32'({ack0_w[0], ack1_w[0], busy_w[0]}), 32'h0);
  endtask

  int         first_ack [4];
  logic [7:0] first_rd  [4];

  initial begin
    m0_rnw = 1'b0; m1_rnw = 1'b0;
    m0_add = 16'h0; m1_add = 16'h0;
    m0_wdata = 8'h0; m1_wdata = 8'h0;
    apply_reset();
    rst_n = 1'b0;
    tick();
    check("rst busy", 32'(busy_w[0]), 32'h0);
    check("rst acks", 32'({ack0_w[0], ack1_w[0]}), 32'h0);
    check("rst rdata", 32'({rdata0_w[0], rdata1_w[0]}), 32'h0);
    check("rst bus", 32'({add_w[0], din_w[0], rd_w[0], wr_w[0]}), 32'h0);
    check("rst state", 32'(state_w[0]), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single write, readback through the slave and the arbiter, then a read from M1.
    run_txn(1'b0, 1'b0, 16'h0001, 8'h5A, 2, 8'h00, "wr m0");
    check("gpio byte", 32'(reg1_w[0]), 32'h5A);
    run_txn(1'b0, 1'b1, 16'h0001, 8'h00, 3, 8'h5A, "rd m0");
    run_txn(1'b1, 1'b1, 16'h0011, 8'h00, 3, 8'hA5, "rd m1");
    check("m0 rdata held", 32'(rdata0_w[0]), 32'h5A);

    // Both masters write from the first cycle after reset and hold REQ for four transactions.
    apply_reset();
    m0_req = 1'b1; m0_rnw = 1'b0; m0_add = 16'h0002; m0_wdata = 8'h11;
    m1_req = 1'b1; m1_rnw = 1'b0; m1_add = 16'h0003; m1_wdata = 8'h22;
    exp_q = {16'h0002, 16'h0003, 16'h0002, 16'h0003};
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("tie wr", 32'({wr_w[0], rd_w[0]}), 32'({(k % 3) == 1, 1'b0}));
      check("tie busy", 32'(busy_w[0]), 32'((k % 3) != 0));
      check("tie acks", 32'({ack0_w[0], ack1_w[0]}), 32'({(k == 2) || (k == 8), (k == 5) || (k == 11)}));
      if (wr_w[0] && exp_q.size() > 0) begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("tie order", 32'(add_w[0]), 32'(e));
        check("tie data", 32'(din_w[0]), (e == 16'h0002) ? 32'h11 : 32'h22);
      end
    end
    check("tie count", 32'(exp_q.size()), 32'h0);
    m0_req = 1'b0;

    // M1 alone back-to-back: strobes every 3 cycles, BUSY low one cycle in between.
    m1_add = 16'h0004; m1_wdata = 8'h33;
    for (int k = 1; k <= 9; k++) begin
      tick();
      check("b2b wr", 32'(wr_w[0]), 32'((k % 3) == 1));
      check("b2b busy", 32'(busy_w[0]), 32'((k % 3) != 0));
      check("b2b ack", 32'(ack1_w[0]), 32'((k % 3) == 2));
    end
    m1_req = 1'b0;

    // Reset while the RD_LATENCY=3 copy is in WAIT.
    apply_reset();
    m0_req = 1'b1; m0_rnw = 1'b1; m0_add = 16'h0020;
    tick();
    check("lat7 strobe", 32'({rd_w[3], add_w[3]}), 32'({1'b1, 16'h0020}));
    tick();
    tick();
    check("lat3 in wait", 32'(state_w[2]), 32'h2);
    rst_n = 1'b0;
    m0_req = 1'b0;
    #1;
    check("midrst busy", 32'({busy_w[2], busy_w[3]}), 32'h0);
    check("midrst bus", 32'({add_w[2], din_w[2], rd_w[2], wr_w[2]}), 32'h0);
    check("midrst state", 32'(state_w[2]), 32'h0);
    check("midrst ack", 32'({ack0_w[2], ack1_w[2]}), 32'h0);
    tick();
    tick();
    check("rst no ack", 32'({ack0_w[2], ack0_w[3]}), 32'h0);

    // Re-issued read; RD_LATENCY 0/3/7 copies ACK at strobe+1, +4, +8 with 0xCD.
    rst_n = 1'b1;
    m0_req = 1'b1;
    for (int g = 0; g < 4; g++) begin first_ack[g] = 0; first_rd[g] = 8'h00; end
    for (int k = 1; k <= 12; k++) begin
      tick();
      for (int g = 1; g < 4; g++) begin
        if (first_ack[g] == 0 && ack0_w[g]) begin
          first_ack[g] = k;
          first_rd[g]  = rdata0_w[g];
        end
      end
    end
    m0_req = 1'b0;
    check("lat0 ack", 32'(first_ack[1]), 32'd2);
    check("lat0 data", 32'(first_rd[1]), 32'hCD);
    check("lat3 ack", 32'(first_ack[2]), 32'd5);
    check("lat3 data", 32'(first_rd[2]), 32'hCD);
    check("lat7 ack", 32'(first_ack[3]), 32'd9);
    check("lat7 data", 32'(first_rd[3]), 32'hCD);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
